piso_byte_serializer: RTL and testbench
=======================================

PISO_BYTE_SERIALIZER -- requirements
Module: piso_byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, words per parallel load; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Din0..Din3  input  WIDTH each  parallel load words; Din3 is the oldest word in stream order.
REQ-006 in_valid  input  1  parallel load request.
REQ-007 in_ready  output  1  block can accept a parallel load this cycle.
REQ-008 Dout  output  WIDTH  current serial output word.
REQ-009 out_valid  output  1  Dout holds a valid word.
REQ-010 out_ready  input  1  downstream accepts Dout this cycle.
REQ-011 out_last  output  1  Dout is the final word of the current load.

Function
REQ-012 Load transfer SHALL occur on a cycle where in_valid && in_ready; word transfer SHALL occur on a cycle where out_valid && out_ready.
REQ-013 FSM SHALL have two states: IDLE (no data held) and SHIFT (words pending).
REQ-014 In IDLE: in_ready=1, out_valid=0; on load transfer, capture all DEPTH words, counter=DEPTH-1, go to SHIFT.
REQ-015 In SHIFT: out_valid=1; Dout SHALL present the words in the order Din3, Din2, Din1, Din0 as captured; each word transfer advances by one word and decrements the counter.
REQ-016 out_last SHALL be 1 exactly when out_valid=1 and counter=0.
REQ-017 On the last-word transfer with in_valid=0: go to IDLE next cycle.
REQ-018 in_ready SHALL be 1 in IDLE, or in SHIFT when out_last && out_ready (combinational pass-through for back-to-back loads).
REQ-019 On the last-word transfer with a simultaneous load transfer: capture the new words, counter=DEPTH-1, stay in SHIFT; no idle bubble; the new Din3 appears on Dout next cycle.
REQ-020 While out_valid=1 and out_ready=0, Dout, out_last and counter SHALL hold stable.
REQ-021 Din changes while in SHIFT and not loading SHALL NOT affect held data.
REQ-022 Latency: the first word SHALL appear on Dout one cycle after its load transfer.
REQ-023 Throughput: with out_ready held at 1 and in_valid held at 1, one word SHALL be emitted every cycle indefinitely.
REQ-024 Counter width SHALL be $clog2(DEPTH); no wrap-around below 0.

Reset
REQ-025 When rst=1 at a clock edge: state=IDLE, counter=0, held words=0, Dout=0, out_valid=0, out_last=0; in_ready=1 from the next cycle.
REQ-026 Reset mid-SHIFT SHALL discard remaining words without emitting them; rst overrides a simultaneous load or word transfer.

Structure
REQ-027 The state enum (IDLE, SHIFT) and the default WIDTH/DEPTH constants SHALL live in shared package piso_pkg.
REQ-028 The block SHALL be flat with no sub-module; the held words form an internal shift register toward Dout.

Verification
REQ-029 Reset: assert rst 2 cycles mid-SHIFT -> out_valid=0, Dout=0, in_ready=1 next cycle.
REQ-030 Single load: Din3..Din0=0xA3,0xA2,0xA1,0xA0 with out_ready=1 -> Dout=A3,A2,A1,A0 on 4 consecutive cycles, out_last only with A0, then IDLE.
REQ-031 Backpressure: same load, out_ready=0 for 3 cycles after the first word -> Dout=A3 stable 4 cycles, then the sequence completes with no loss.
REQ-032 Back-to-back: second load 0x13..0x10 held valid -> accepted on the A0 cycle, Dout=A0 then 13 on the next cycle, 8 words in 8 cycles.
REQ-033 Din disturbance: change Din every cycle during SHIFT -> output equals the captured words only.
REQ-034 Scoreboard: random in_valid/out_ready for 1000 loads -> output stream equals loaded words in Din3->Din0 order, with exactly one out_last per load.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO byte serializer: FSM state encoding and
// the default word width / load depth.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int unsigned PISO_DEF_WIDTH = 8;
    localparam int unsigned PISO_DEF_DEPTH = 4;
    localparam int unsigned PISO_NUM_PORTS = 4;

    // Counter width for a given depth (never zero, DEPTH is at least 2).
    function automatic int unsigned piso_cnt_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage : piso_pkg

// File: rtl/piso_byte_serializer.sv
// Parallel-in serial-out word serializer with valid/ready on both sides.
// Din3 leaves first; a load can overlap the last word for gap-free streaming.
module piso_byte_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_DEF_WIDTH,
    parameter int unsigned DEPTH = PISO_DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Din0,
    input  logic [WIDTH-1:0] Din1,
    input  logic [WIDTH-1:0] Din2,
    input  logic [WIDTH-1:0] Din3,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int unsigned CNT_W = piso_cnt_w(DEPTH);

    piso_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_words [DEPTH];
    logic             r_out_valid;
    logic             r_out_last;

    logic [WIDTH-1:0] w_din        [PISO_NUM_PORTS];
    logic [WIDTH-1:0] w_load_words [DEPTH];
    logic             w_in_ready;
    logic             w_load;
    logic             w_xfer;

    assign w_din[0] = Din0;
    assign w_din[1] = Din1;
    assign w_din[2] = Din2;
    assign w_din[3] = Din3;

    // The ports fill the oldest slots (Din3 at the head); any extra slots
    // for DEPTH above the port count load as zero.
    always_comb begin
        // NOTE: every slot gets a default first so no path leaves it unassigned (no latch).
        for (int i = 0; i < DEPTH; i++) begin
            w_load_words[i] = '0;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (k < PISO_NUM_PORTS) begin
                w_load_words[DEPTH-1-k] = w_din[PISO_NUM_PORTS-1-k];
            end
        end
    end

    // Ready passes straight through from out_ready on the last word so a
    // new load can replace it without an idle cycle.
    assign w_in_ready = (r_state == IDLE) || (r_out_last && out_ready);
    assign w_load     = in_valid && w_in_ready;
    assign w_xfer     = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            // NOTE: the word store is cleared on reset because Dout reads it directly.
            for (int i = 0; i < DEPTH; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_words     <= w_load_words;
                        r_cnt       <= CNT_W'(DEPTH - 1);
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_xfer) begin
                        if (r_cnt == '0) begin
                            if (w_load) begin
                                r_words     <= w_load_words;
                                r_cnt       <= CNT_W'(DEPTH - 1);
                                r_out_valid <= 1'b1;
                                r_out_last  <= 1'b0;
                            end else begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    r_words[i] <= '0;
                                end
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_state     <= IDLE;
                            end
                        end else begin
                            // Advance toward the head; the tail refills with zero.
                            for (int i = DEPTH - 1; i > 0; i--) begin
                                r_words[i] <= r_words[i-1];
                            end
                            r_words[0] <= '0;
                            r_cnt      <= r_cnt - 1'b1;
                            r_out_last <= (r_cnt == CNT_W'(1));
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign Dout      = r_words[DEPTH-1];
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule : piso_byte_serializer

// File: tb/tb_piso_byte_serializer.sv
// Self-checking bench for piso_byte_serializer: directed scenarios followed by
// a randomized run, all compared against a queue-based model of the word stream.
module tb_piso_byte_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din [4];
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    int n_checks;
    int n_fail;

    // Model: words still owed to the downstream, head first.
    logic [7:0] q [$];

    bit accepted;
    int xfer_cnt;
    int dut_last_cnt;
    int model_load_cnt;

    piso_byte_serializer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .Din0      (din[0]),
        .Din1      (din[1]),
        .Din2      (din[2]),
        .Din3      (din[3]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
        din[3] = d3;
        din[2] = d2;
        din[1] = d1;
        din[0] = d0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic iv, input logic ordy, input logic do_rst);
        logic exp_valid;
        logic exp_last;
        logic exp_ready;
        in_valid  = iv;
        out_ready = ordy;
        rst       = do_rst;
        #1;
        exp_valid = (q.size() > 0);
        exp_last  = (q.size() == 1);
        exp_ready = (q.size() == 0) || (q.size() == 1 && ordy);
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        check("out_last",  {31'b0, out_last},  {31'b0, exp_last});
        check("in_ready",  {31'b0, in_ready},  {31'b0, exp_ready});
        if (exp_valid) begin
            check("dout", {24'b0, dout}, {24'b0, q[0]});
        end
        if (out_valid && out_last && ordy && !do_rst) begin
            dut_last_cnt++;
        end
        accepted = 1'b0;
        if (do_rst) begin
            q.delete();
        end else begin
            if (exp_valid && ordy) begin
                void'(q.pop_front());
                xfer_cnt++;
            end
            if (iv && exp_ready) begin
                q.push_back(din[3]);
                q.push_back(din[2]);
                q.push_back(din[1]);
                q.push_back(din[0]);
                accepted = 1'b1;
                model_load_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        xfer_cnt = 0;
        dut_last_cnt   = 0;
        model_load_cnt = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        set_din(8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Reset state.
        #1;
        check("rst_dout",      {24'b0, dout},      32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_last",  {31'b0, out_last},  32'h0);
        check("rst_in_ready",  {31'b0, in_ready},  32'h1);

        // Single load, streaming straight through, then idle.
        set_din(8'hA3, 8'hA2, 8'hA1, 8'hA0);
        step(1'b1, 1'b1, 1'b0);
        check("single_accept", {31'b0, accepted}, 32'h1);
        set_din(8'h55, 8'h66, 8'h77, 8'h88);
        check("single_w0", {24'b0, dout}, 32'hA3);
        step(1'b0, 1'b1, 1'b0);
        check("single_w1", {24'b0, dout}, 32'hA2);
        step(1'b0, 1'b1, 1'b0);
        check("single_w2", {24'b0, dout}, 32'hA1);
        step(1'b0, 1'b1, 1'b0);
        check("single_w3", {24'b0, dout}, 32'hA0);
        check("single_last", {31'b0, out_last}, 32'h1);
        step(1'b0, 1'b1, 1'b0);
        check("single_idle", {31'b0, out_valid}, 32'h0);
        step(1'b0, 1'b1, 1'b0);

        // Backpressure: A3 held for four cycles, then the rest with no loss.
        set_din(8'hA3, 8'hA2, 8'hA1, 8'hA0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", {24'b0, dout}, 32'hA3);
            step(1'b0, 1'b0, 1'b0);
        end
        check("bp_hold4", {24'b0, dout}, 32'hA3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
        end
        check("bp_drained", {31'b0, out_valid}, 32'h0);

        // Back-to-back: second load held valid, accepted on the A0 cycle.
        set_din(8'hA3, 8'hA2, 8'hA1, 8'hA0);
        step(1'b1, 1'b1, 1'b0);
        set_din(8'h13, 8'h12, 8'h11, 8'h10);
        xfer_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                check("b2b_a0", {24'b0, dout}, 32'hA0);
            end
            if (i == 4) begin
                check("b2b_13", {24'b0, dout}, 32'h13);
            end
            step(model_load_cnt < 5 ? 1'b1 : 1'b0, 1'b1, 1'b0);
            if (i == 3) begin
                check("b2b_accept_on_last", {31'b0, accepted}, 32'h1);
            end
        end
        check("b2b_8_in_8", xfer_cnt, 32'd8);
        step(1'b0, 1'b1, 1'b0);

        // Din disturbance during SHIFT, with some backpressure mixed in.
        set_din(8'hC3, 8'hC2, 8'hC1, 8'hC0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            set_din(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step(1'b0, (i % 3) != 1, 1'b0);
        end
        check("dist_drained", {31'b0, out_valid}, 32'h0);

        // Reset mid-SHIFT discards the rest of the load.
        set_din(8'hE3, 8'hE2, 8'hE1, 8'hE0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("midrst_dout",      {24'b0, dout},      32'h0);
        check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_in_ready",  {31'b0, in_ready},  32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Randomized scoreboard run: 1000 loads, exactly one out_last each.
        begin
            int target;
            int budget;
            logic iv;
            target = model_load_cnt + 1000;
            dut_last_cnt = 0;
            budget = 0;
            iv = 1'b0;
            while ((model_load_cnt < target || q.size() != 0) && budget < 30000) begin
                if (!iv || accepted) begin
                    set_din(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                end
                iv = (model_load_cnt < target) && ($urandom_range(0, 3) != 0);
                step(iv, $urandom_range(0, 3) != 0, 1'b0);
                budget++;
            end
            check("rand_budget", {31'b0, budget < 30000}, 32'h1);
            check("rand_loads",  model_load_cnt, target);
            check("rand_lasts",  dut_last_cnt, 32'd1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_byte_serializer
